// File: rtl/pattern_event_counter_if.sv
// Report handshake bundle between the event counter and its consumer.
// Producer drives valid and both count fields; consumer drives ready.
interface pattern_event_counter_if #(
    parameter int CW = 8
);
    logic          rpt_valid;
    logic          rpt_ready;
    logic [CW-1:0] rpt_cnt010;
    logic [CW-1:0] rpt_cnt101;

    modport master (
        output rpt_valid,
        output rpt_cnt010,
        output rpt_cnt101,
        input  rpt_ready
    );

    modport slave (
        input  rpt_valid,
        input  rpt_cnt010,
        input  rpt_cnt101,
        output rpt_ready
    );
endinterface

// File: rtl/pattern_event_counter.sv
// Windowed counter of 010/101 detector hits with a one-entry report buffer
// and a sticky overrun flag for reports dropped while the buffer is full.
module pattern_event_counter #(
    parameter int WINDOW     = 16,
    parameter int CW         = 8,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic [1:0] hit,
    output logic       busy,
    output logic       overrun,
    pattern_event_counter_if.master rpt
);
    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [15:0]   LAST = 16'(WINDOW - 1);
    localparam logic [CW-1:0] CMAX = '1;

    state_t        state;
    state_t        state_nxt;
    logic [15:0]   idx;
    logic [CW-1:0] cnt010;
    logic [CW-1:0] cnt101;
    logic [CW-1:0] n010;
    logic [CW-1:0] n101;
    logic          go;
    logic          close;
    logic          load;

    assign busy = (state == COUNT);

    // Saturating next counts, including the sample at this edge.
    assign n010 = cnt010 + CW'(hit[1] && (cnt010 != CMAX));
    assign n101 = cnt101 + CW'(hit[0] && (cnt101 != CMAX));

    assign load = close && (!rpt.rpt_valid || rpt.rpt_ready);

    always_comb begin
        state_nxt = state;
        go        = 1'b0;
        close     = 1'b0;
        case (state)
            IDLE: begin
                if (start && !stop) begin
                    go        = 1'b1;
                    state_nxt = COUNT;
                end
            end
            COUNT: begin
                if (stop) begin
                    state_nxt = IDLE;
                end else if (idx == LAST) begin
                    close = 1'b1;
                    if (!CONTINUOUS) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idx            <= '0;
            cnt010         <= '0;
            cnt101         <= '0;
            overrun        <= 1'b0;
            rpt.rpt_valid  <= 1'b0;
            rpt.rpt_cnt010 <= '0;
            rpt.rpt_cnt101 <= '0;
        end else begin
            if (go) begin
                idx     <= '0;
                cnt010  <= '0;
                cnt101  <= '0;
                overrun <= 1'b0;
            end else if (state == COUNT && !stop) begin
                if (close) begin
                    idx    <= '0;
                    cnt010 <= '0;
                    cnt101 <= '0;
                end else begin
                    idx    <= idx + 16'd1;
                    cnt010 <= n010;
                    cnt101 <= n101;
                end
            end
            // A close that cannot load means the buffer is full and unread.
            if (load) begin
                rpt.rpt_valid  <= 1'b1;
                rpt.rpt_cnt010 <= n010;
                rpt.rpt_cnt101 <= n101;
            end else begin
                if (close) overrun <= 1'b1;
                if (rpt.rpt_valid && rpt.rpt_ready) rpt.rpt_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pattern_event_counter.sv
// Directed bench for pattern_event_counter across three parameter sets:
// a: W=10 CW=8 single, b: W=8 CW=2 single, c: W=4 CW=8 continuous.
module tb_pattern_event_counter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    logic       a_start = 0, a_stop = 0, a_busy, a_ovr;
    logic [1:0] a_hit = 0;
    logic       b_start = 0, b_stop = 0, b_busy, b_ovr;
    logic [1:0] b_hit = 0;
    logic       c_start = 0, c_stop = 0, c_busy, c_ovr;
    logic [1:0] c_hit = 0;

    pattern_event_counter_if #(.CW(8)) a_if ();
    pattern_event_counter_if #(.CW(2)) b_if ();
    pattern_event_counter_if #(.CW(8)) c_if ();

    pattern_event_counter #(.WINDOW(10), .CW(8), .CONTINUOUS(1'b0)) u_a (
        .clock(clock), .reset(reset), .start(a_start), .stop(a_stop),
        .hit(a_hit), .busy(a_busy), .overrun(a_ovr), .rpt(a_if.master)
    );
    pattern_event_counter #(.WINDOW(8), .CW(2), .CONTINUOUS(1'b0)) u_b (
        .clock(clock), .reset(reset), .start(b_start), .stop(b_stop),
        .hit(b_hit), .busy(b_busy), .overrun(b_ovr), .rpt(b_if.master)
    );
    pattern_event_counter #(.WINDOW(4), .CW(8), .CONTINUOUS(1'b1)) u_c (
        .clock(clock), .reset(reset), .start(c_start), .stop(c_stop),
        .hit(c_hit), .busy(c_busy), .overrun(c_ovr), .rpt(c_if.master)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [1:0] seq2 [10];

    initial begin
        a_if.rpt_ready = 0;
        b_if.rpt_ready = 0;
        c_if.rpt_ready = 0;
        seq2 = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
                 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};

        // T1: reset values, then reset mid-window
        step(); step();
        reset = 0;
        chk("t1_busy0", a_busy, 0);
        chk("t1_valid0", a_if.rpt_valid, 0);
        chk("t1_c010", a_if.rpt_cnt010, 0);
        chk("t1_c101", a_if.rpt_cnt101, 0);
        chk("t1_ovr0", a_ovr, 0);
        chk("t1_b_valid0", b_if.rpt_valid, 0);
        chk("t1_c_busy0", c_busy, 0);
        a_start = 1;
        step();
        a_start = 0;
        a_hit = 2'b01;
        chk("t1_busy_start", a_busy, 1);
        step(); step(); step();
        reset = 1;
        a_hit = 0;
        step(); step();
        reset = 0;
        chk("t1_busy_rst", a_busy, 0);
        chk("t1_valid_rst", a_if.rpt_valid, 0);
        step();
        chk("t1_valid_after", a_if.rpt_valid, 0);
        chk("t1_busy_after", a_busy, 0);

        // T2: W=10 detector sequence -> 2/3
        a_if.rpt_ready = 1;
        a_start = 1;
        step();
        a_start = 0;
        for (int i = 0; i < 10; i++) begin
            a_hit = seq2[i];
            step();
            if (i < 9) begin
                chk("t2_busy_mid", a_busy, 1);
                chk("t2_valid_mid", a_if.rpt_valid, 0);
            end
        end
        a_hit = 0;
        chk("t2_busy_fall", a_busy, 0);
        chk("t2_valid", a_if.rpt_valid, 1);
        chk("t2_c010", a_if.rpt_cnt010, 2);
        chk("t2_c101", a_if.rpt_cnt101, 3);
        step();
        chk("t2_xfer", a_if.rpt_valid, 0);

        // T3: CW=2 saturation with hit=11
        b_start = 1;
        step();
        b_start = 0;
        b_hit = 2'b11;
        for (int i = 0; i < 8; i++) step();
        b_hit = 0;
        chk("t3_valid", b_if.rpt_valid, 1);
        chk("t3_c010", b_if.rpt_cnt010, 3);
        chk("t3_c101", b_if.rpt_cnt101, 3);
        chk("t3_busy", b_busy, 0);
        b_if.rpt_ready = 1;
        step();
        b_if.rpt_ready = 0;
        chk("t3_xfer", b_if.rpt_valid, 0);

        // T5: stop mid-window, stop on close edge, start+stop
        b_start = 1;
        step();
        b_start = 0;
        b_hit = 2'b01;
        step(); step();
        b_stop = 1;
        step();
        b_stop = 0;
        chk("t5_stop_busy", b_busy, 0);
        chk("t5_stop_valid", b_if.rpt_valid, 0);
        b_start = 1;
        step();
        b_start = 0;
        for (int i = 0; i < 7; i++) step();
        b_stop = 1;
        step();
        b_stop = 0;
        b_hit = 0;
        chk("t5_close_busy", b_busy, 0);
        chk("t5_close_valid", b_if.rpt_valid, 0);
        step();
        chk("t5_close_valid2", b_if.rpt_valid, 0);
        b_start = 1;
        b_stop = 1;
        step();
        b_start = 0;
        b_stop = 0;
        chk("t5_ss_busy", b_busy, 0);

        // T4: continuous, consumer stalled -> overrun
        c_hit = 2'b01;
        c_start = 1;
        step();
        c_start = 0;
        for (int i = 0; i < 4; i++) step();
        chk("t4_valid", c_if.rpt_valid, 1);
        chk("t4_c010", c_if.rpt_cnt010, 0);
        chk("t4_c101", c_if.rpt_cnt101, 4);
        chk("t4_busy", c_busy, 1);
        chk("t4_ovr0", c_ovr, 0);
        c_hit = 2'b10;
        for (int i = 0; i < 4; i++) step();
        chk("t4_ovr1", c_ovr, 1);
        chk("t4_keep_v", c_if.rpt_valid, 1);
        chk("t4_keep010", c_if.rpt_cnt010, 0);
        chk("t4_keep101", c_if.rpt_cnt101, 4);
        c_hit = 0;
        c_if.rpt_ready = 1;
        step();
        c_if.rpt_ready = 0;
        chk("t4_xfer", c_if.rpt_valid, 0);
        step();
        chk("t4_one_xfer", c_if.rpt_valid, 0);
        chk("t4_ovr_sticky", c_ovr, 1);
        c_stop = 1;
        step();
        c_stop = 0;
        chk("t4_stop_busy", c_busy, 0);
        chk("t4_ovr_idle", c_ovr, 1);

        // T6: restart clears overrun; ready only on close edges
        c_start = 1;
        step();
        c_start = 0;
        chk("t6_ovr_clr", c_ovr, 0);
        c_hit = 2'b01;
        for (int i = 0; i < 4; i++) step();
        chk("t6_a_valid", c_if.rpt_valid, 1);
        chk("t6_a_c101", c_if.rpt_cnt101, 4);
        c_hit = 2'b10;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_b_hold", c_if.rpt_valid, 1);
        end
        c_if.rpt_ready = 1;
        step();
        c_if.rpt_ready = 0;
        chk("t6_b_valid", c_if.rpt_valid, 1);
        chk("t6_b_c010", c_if.rpt_cnt010, 4);
        chk("t6_b_c101", c_if.rpt_cnt101, 0);
        c_hit = 2'b11;
        for (int i = 0; i < 3; i++) step();
        c_if.rpt_ready = 1;
        step();
        c_if.rpt_ready = 0;
        chk("t6_c_valid", c_if.rpt_valid, 1);
        chk("t6_c_c010", c_if.rpt_cnt010, 4);
        chk("t6_c_c101", c_if.rpt_cnt101, 4);
        chk("t6_ovr", c_ovr, 0);
        c_hit = 0;
        c_if.rpt_ready = 1;
        step();
        c_if.rpt_ready = 0;
        chk("t6_drain", c_if.rpt_valid, 0);
        c_stop = 1;
        step();
        c_stop = 0;
        chk("t6_stop_busy", c_busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
